// File: rtl/snake_dir_sched.sv
// Direction scheduler: arbitrates key pulses, filters illegal turns, buffers up to two
// turns and applies one per movement tick, with IDLE/RUN/OVER game sequencing.
module snake_dir_sched #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       leftpress,
    input  logic       rightpress,
    input  logic       uppress,
    input  logic       downpress,
    input  logic       pause,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       step,
    output logic       running,
    output logic [1:0] q_count,
    output logic       drop
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OVER
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       slot0_q, slot0_d;
    logic [1:0]       slot1_q, slot1_d;
    logic [1:0]       q_count_q, q_count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             drop_q, drop_d;
    logic             running_q, running_d;

    logic       any_press;
    logic       multi_press;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       tick;
    logic       pop;
    logic       legal;
    logic       push;

    assign any_press   = uppress | downpress | leftpress | rightpress;
    assign multi_press = (uppress & (downpress | leftpress | rightpress))
                       | (downpress & (leftpress | rightpress))
                       | (leftpress & rightpress);

    always_comb begin
        if (uppress)        cand = DIR_UP;
        else if (downpress) cand = DIR_DOWN;
        else if (leftpress) cand = DIR_LEFT;
        else                cand = DIR_RIGHT;
    end

    // A new turn is judged against the last heading it would follow: the queue tail,
    // or the live heading when nothing is buffered. Opposites differ only in bit 0.
    assign ref_dir = (q_count_q == 2'd2) ? slot1_q :
                     (q_count_q == 2'd1) ? slot0_q : dir_q;
    assign tick    = (cnt_q == CNT_LAST) && !pause;
    assign pop     = tick && (q_count_q != 2'd0);
    assign legal   = (cand != ref_dir) && (cand != {ref_dir[1], ~ref_dir[0]});
    assign push    = any_press && legal && ((q_count_q != 2'd2) || pop);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
        state_d   = state_q;
        dir_d     = dir_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        q_count_d = q_count_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        step_d    = 1'b0;
        drop_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                q_count_d = 2'd0;
                if (any_press) begin
                    dir_d     = cand;
                    state_d   = ST_RUN;
                    running_d = 1'b1;
                    drop_d    = multi_press;
                end
            end

            ST_RUN: begin
                if (game_over) begin
                    state_d   = ST_OVER;
                    running_d = 1'b0;
                    q_count_d = 2'd0;
                    cnt_d     = '0;
                end else begin
                    drop_d = any_press && (multi_press || !push);

                    if (tick) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                    end else if (!pause) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end

                    if (pop) begin
                        dir_d   = slot0_q;
                        slot0_d = slot1_q;
                    end

                    // Simultaneous push+pop keeps the count; the new turn lands behind
                    // whatever survives the pop.
                    unique case ({push, pop})
                        2'b10: begin
                            if (q_count_q == 2'd0) slot0_d = cand;
                            else                   slot1_d = cand;
                            q_count_d = q_count_q + 2'd1;
                        end
                        2'b01: q_count_d = q_count_q - 2'd1;
                        2'b11: begin
                            if (q_count_q == 2'd1) slot0_d = cand;
                            else                   slot1_d = cand;
                        end
                        default: ;
                    endcase
                end
            end

            ST_OVER: begin
                if (!game_over) begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_RIGHT;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_RIGHT;
            slot0_q   <= DIR_UP;
            slot1_q   <= DIR_UP;
            q_count_q <= 2'd0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            drop_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            q_count_q <= q_count_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            drop_q    <= drop_d;
            running_q <= running_d;
        end
    end

    assign dir     = dir_q;
    assign step    = step_q;
    assign running = running_q;
    assign q_count = q_count_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_snake_dir_sched.sv
// Scoreboard bench for snake_dir_sched: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_snake_dir_sched;

    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       leftpress = 1'b0, rightpress = 1'b0, uppress = 1'b0, downpress = 1'b0;
    logic       pause = 1'b0, game_over = 1'b0;
    logic [1:0] dir, q_count;
    logic       step, running, drop;

    snake_dir_sched #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .leftpress  (leftpress),
        .rightpress (rightpress),
        .uppress    (uppress),
        .downpress  (downpress),
        .pause      (pause),
        .game_over  (game_over),
        .dir        (dir),
        .step       (step),
        .running    (running),
        .q_count    (q_count),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] dir;
        logic       step;
        logic       running;
        logic [1:0] qc;
        logic       drop;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Behavioural model: headings 0 up, 1 down, 2 left, 3 right.
    typedef enum int {M_IDLE, M_RUN, M_OVER} mstate_e;
    mstate_e m_state = M_IDLE;
    int      m_dir = 3;
    int      m_cnt = 0;
    int      m_turns[$];
    bit      m_step = 0, m_drop = 0, m_running = 0;

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_cycle(input bit r, input bit [3:0] keys, input bit p, input bit g);
        int n;
        int cand;
        int ref_d;
        bit tick;
        bit accept;
        n = 0;
        cand = -1;
        for (int k = 0; k < 4; k++) begin
            if (keys[3-k]) begin
                n++;
                if (cand < 0) cand = k;
            end
        end
        m_step = 0;
        m_drop = 0;
        if (!r) begin
            m_state = M_IDLE; m_dir = 3; m_cnt = 0; m_turns.delete(); m_running = 0;
            return;
        end
        case (m_state)
            M_IDLE: begin
                if (n > 0) begin
                    m_dir = cand; m_state = M_RUN; m_running = 1; m_cnt = 0;
                    m_drop = (n > 1);
                end
            end
            M_RUN: begin
                if (g) begin
                    m_state = M_OVER; m_running = 0; m_turns.delete(); m_cnt = 0;
                end else begin
                    tick = !p && (m_cnt == TD - 1);
                    ref_d = (m_turns.size() > 0) ? m_turns[$] : m_dir;
                    accept = 0;
                    if (n > 0) begin
                        if (cand == ref_d || cand == opposite(ref_d)) accept = 0;
                        else if (m_turns.size() == 2 && !tick)       accept = 0;
                        else                                          accept = 1;
                        m_drop = (n > 1) || !accept;
                    end
                    if (tick) begin
                        m_cnt = 0;
                        m_step = 1;
                        if (m_turns.size() > 0) m_dir = m_turns.pop_front();
                    end else if (!p) begin
                        m_cnt++;
                    end
                    if (accept) m_turns.push_back(cand);
                end
            end
            default: begin
                if (!g) begin
                    m_state = M_IDLE; m_dir = 3;
                end
            end
        endcase
    endtask

    // One clock of stimulus: drive at the falling edge, predict the post-edge outputs.
    task automatic drive(input bit r, input bit [3:0] keys, input bit p, input bit g);
        exp_t e;
        @(negedge clk);
        rst = r;
        uppress = keys[3]; downpress = keys[2]; leftpress = keys[1]; rightpress = keys[0];
        pause = p; game_over = g;
        model_cycle(r, keys, p, g);
        cyc++;
        e.cyc = cyc; e.dir = 2'(m_dir); e.step = m_step; e.running = m_running;
        e.qc = 2'(m_turns.size()); e.drop = m_drop;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit p = 0);
        for (int i = 0; i < n; i++) drive(1, 4'b0000, p, 0);
    endtask

    task automatic check(input string name, input int c, input logic [1:0] act, input logic [1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endtask

    // Monitor: compares whatever the DUT presents after each active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dir",     e.cyc, dir,             e.dir);
                check("step",    e.cyc, {1'b0, step},    {1'b0, e.step});
                check("running", e.cyc, {1'b0, running}, {1'b0, e.running});
                check("q_count", e.cyc, q_count,         e.qc);
                check("drop",    e.cyc, {1'b0, drop},    {1'b0, e.drop});
            end
        end
    end

    localparam bit [3:0] K_UP = 4'b1000, K_DN = 4'b0100, K_LF = 4'b0010, K_RT = 4'b0001;

    initial begin
        int  guard;
        bit  r_p, r_g;
        bit [3:0] keys;

        // Reset for two cycles.
        drive(0, 4'b0000, 0, 0);
        drive(0, 4'b0000, 0, 0);
        idle(2);

        // Start with up; watch a few steps.
        drive(1, K_UP, 0, 0);
        idle(3 * TD + 2);

        // Restart heading right, then illegal / queued / full-queue presses.
        drive(0, 4'b0000, 0, 0);
        drive(1, K_RT, 0, 0);
        idle(1);
        drive(1, K_LF, 0, 0);
        drive(1, K_UP, 0, 0);
        drive(1, K_LF, 0, 0);
        drive(1, K_DN, 0, 0);
        idle(2 * TD + 2);

        // Same-cycle up+left while heading left: up wins and is queued, left drops.
        drive(1, K_UP | K_LF, 0, 0);
        idle(TD + 1);

        // Pause when the tick counter reads 3.
        guard = 0;
        while (m_cnt != 3 && guard < 4 * TD) begin
            idle(1);
            guard++;
        end
        if (guard >= 4 * TD) begin
            fails++;
            $display("FAIL pause_align: counter never reached 3");
        end
        idle(5, 1);
        drive(1, K_RT, 1, 0);
        drive(1, K_DN, 1, 0);
        idle(13, 1);
        idle(TD + 3);

        // Game over landing on a step edge.
        guard = 0;
        while (m_cnt != TD - 1 && guard < 4 * TD) begin
            idle(1);
            guard++;
        end
        drive(1, 4'b0000, 0, 1);
        drive(1, K_LF, 0, 1);
        drive(1, K_UP | K_DN, 0, 1);
        drive(1, 4'b0000, 0, 0);
        idle(2);

        // Reset in the middle of a run.
        drive(1, K_DN, 0, 0);
        drive(1, K_LF, 0, 0);
        idle(3);
        drive(0, K_UP, 0, 0);
        idle(2);

        // Random traffic.
        r_p = 0;
        r_g = 0;
        for (int i = 0; i < 3000; i++) begin
            keys = '0;
            for (int k = 0; k < 4; k++) keys[k] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) r_p = ~r_p;
            if (!r_g && $urandom_range(0, 149) == 0) r_g = 1;
            else if (r_g && $urandom_range(0, 3) == 0) r_g = 0;
            drive($urandom_range(0, 399) != 0, keys, r_p, r_g);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries never compared", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
